// File: rtl/tm_pkg.sv
// Shared types and constants for the weighted traffic manager.
// Optional feature macro used by the top: TM_STRICT_PRIO_EN.
package tm_pkg;

  localparam int TM_NUM_QUEUES   = 4;
  localparam int TM_QUEUE_DEPTH  = 16;
  localparam int TM_DATA_WIDTH   = 512;
  localparam int TM_WEIGHT_WIDTH = 4;

  localparam int QW = $clog2(TM_NUM_QUEUES);
  localparam int OW = $clog2(TM_QUEUE_DEPTH) + 1;

  typedef logic [QW-1:0] qidx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  // Occupancy needs one extra bit so that a completely full queue is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tm_queue_fifo.sv
// Single-clock circular-buffer FIFO with occupancy, full and empty flags.
// The head word is presented combinationally so the caller can register it on pop.
module tm_queue_fifo
  import tm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic [occ_width(DEPTH)-1:0]  occupancy_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/weighted_traffic_manager.sv
// Multi-queue traffic manager: tail-dropping ingress FIFOs drained by a WRR scheduler.
// Define TM_STRICT_PRIO_EN to make queue 0 strict-priority ahead of the WRR queues.
module weighted_traffic_manager
  import tm_pkg::*;
#(
  parameter int NUM_QUEUES   = 4,
  parameter int QUEUE_DEPTH  = 16,
  parameter int DATA_WIDTH   = 512,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            enable,
  input  logic                                            in_valid,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic [$clog2(NUM_QUEUES)-1:0]                   in_queue,
  output logic                                            in_ready,
  output logic                                            out_valid,
  output logic [DATA_WIDTH-1:0]                           out_data,
  output logic [$clog2(NUM_QUEUES)-1:0]                   out_queue,
  input  logic                                            out_ready,
  output logic [NUM_QUEUES-1:0]                           queue_full,
  output logic [NUM_QUEUES-1:0]                           queue_empty,
  output logic [NUM_QUEUES*occ_width(QUEUE_DEPTH)-1:0]    queue_occupancy,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0]              scheduler_weights,
  output logic [31:0]                                     drop_count
);

  localparam int QIW   = $clog2(NUM_QUEUES);
  localparam int OCC_W = occ_width(QUEUE_DEPTH);

  logic [NUM_QUEUES-1:0]   push_vec, pop_vec, wrr_ready;
  logic [DATA_WIDTH-1:0]   head_data [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] weight_arr [NUM_QUEUES];
  logic                    push_req, drop_evt, prio_hit, load_slot;

  sched_state_e            state_q, state_d;
  logic [QIW-1:0]          cur_q_q, cur_q_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [QIW-1:0]          out_queue_q, out_queue_d;
  logic [31:0]             drop_count_q, drop_count_d;

  logic                    pick_valid;
  logic [QIW-1:0]          pick_q, cand_idx;
  logic [WEIGHT_WIDTH-1:0] cand_w;

  assign in_ready = enable;
  assign push_req = in_valid && enable;
  // Fullness is judged before any same-cycle pop, so a full target always drops.
  assign drop_evt = push_req && queue_full[in_queue];

  generate
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      assign push_vec[gi]   = push_req && (in_queue == QIW'(gi));
      assign weight_arr[gi] = scheduler_weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];

      tm_queue_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_vec[gi]),
        .push_data_i (in_data),
        .pop_i       (pop_vec[gi]),
        .pop_data_o  (head_data[gi]),
        .occupancy_o (queue_occupancy[gi*OCC_W +: OCC_W]),
        .full_o      (queue_full[gi]),
        .empty_o     (queue_empty[gi])
      );
    end
  endgenerate

`ifdef TM_STRICT_PRIO_EN
  localparam logic [NUM_QUEUES-1:0] WRR_MASK = ~NUM_QUEUES'(1);
  assign prio_hit = !queue_empty[0];
`else
  localparam logic [NUM_QUEUES-1:0] WRR_MASK = '1;
  assign prio_hit = 1'b0;
`endif

  assign wrr_ready = ~queue_empty & WRR_MASK;
  assign load_slot = !out_valid_q || out_ready;

  always_comb begin
    pick_valid   = 1'b0;
    pick_q       = '0;
    cand_idx     = '0;
    cand_w       = '0;
    cur_q_d      = cur_q_q;
    credit_d     = credit_q;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_queue_d  = out_queue_q;
    pop_vec      = '0;
    drop_count_d = drop_count_q;

    if (load_slot && enable) begin
      if (prio_hit) begin
        // Strict-priority service leaves the WRR position and credit untouched.
        pick_valid = 1'b1;
        pick_q     = '0;
      end else if (wrr_ready[cur_q_q] && (credit_q != '0)) begin
        pick_valid = 1'b1;
        pick_q     = cur_q_q;
        credit_d   = credit_q - WEIGHT_WIDTH'(1);
      end else begin
        for (int k = 1; k <= NUM_QUEUES; k++) begin
          cand_idx = QIW'((int'(cur_q_q) + k) % NUM_QUEUES);
          if (!pick_valid && wrr_ready[cand_idx]) begin
            pick_valid = 1'b1;
            pick_q     = cand_idx;
            cur_q_d    = cand_idx;
            cand_w     = weight_arr[cand_idx];
            credit_d   = (cand_w == '0) ? '0 : cand_w - WEIGHT_WIDTH'(1);
          end
        end
      end
    end

    if (load_slot) begin
      out_valid_d = pick_valid;
      state_d     = pick_valid ? SERVE : IDLE;
      if (pick_valid) begin
        out_data_d      = head_data[pick_q];
        out_queue_d     = pick_q;
        pop_vec[pick_q] = 1'b1;
      end
    end

    if (drop_evt && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q_q      <= QIW'(NUM_QUEUES - 1);
      credit_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_queue_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_q_q      <= cur_q_d;
      credit_q     <= credit_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_queue_q  <= out_queue_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_queue  = out_queue_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/weighted_traffic_manager.md
Name: weighted_traffic_manager

Overview:
Multi-queue traffic manager with real per-queue buffering and a weighted round-robin (WRR) egress scheduler.
- Ingress: packet words are steered by queue index into NUM_QUEUES FIFOs; a write to a full queue is tail-dropped and counted.
- Egress: WRR drains the queues through a registered valid/ready output stage.
- Sits between packet_classifier and the egress packet_processing_pipeline.

Parameters:
NUM_QUEUES, 4, number of queues (>=2).
QUEUE_DEPTH, 16, words per queue (power of 2, >=2).
DATA_WIDTH, 512, packet word width.
WEIGHT_WIDTH, 4, bits per queue weight.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  global enable
in_valid  in  1  ingress word valid
in_data  in  DATA_WIDTH  ingress word
in_queue  in  $clog2(NUM_QUEUES)  target queue
in_ready  out  1  ingress ready
out_valid  out  1  egress valid
out_data  out  DATA_WIDTH  egress word
out_queue  out  $clog2(NUM_QUEUES)  source queue of out_data
out_ready  in  1  egress ready
queue_full  out  NUM_QUEUES  per-queue full
queue_empty  out  NUM_QUEUES  per-queue empty
queue_occupancy  out  NUM_QUEUES*($clog2(QUEUE_DEPTH)+1)  packed counts; queue i at [i*OW +: OW]
scheduler_weights  in  NUM_QUEUES*WEIGHT_WIDTH  packed weights; queue i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
drop_count  out  32  tail-drop counter, saturating at 0xFFFFFFFF

Behaviour:
- Reset (rst_n=0 at posedge): all queues empty, occupancy 0, queue_empty all 1, queue_full all 0, out_valid 0, out_data 0, out_queue 0, drop_count 0. Scheduler state IDLE, cur_q=NUM_QUEUES-1, credit=0. Reset mid-operation discards all buffered words.
- in_ready = enable (combinational).
- Push condition: in_valid && in_ready.
  - Queue not full: word is written; occupancy +1 at the next edge.
  - Queue full: word is dropped and drop_count increments.
  - Fullness is judged on current occupancy, so a simultaneous pop from the same full queue does not save the word.
- Push and pop on the same queue in the same cycle: occupancy unchanged.
- Output stage is a single register.
  - load_slot = !out_valid || out_ready.
  - While out_valid && !out_ready: out_data and out_queue hold stable.
  - If load_slot and no queue is selectable: out_valid clears at the next edge.
- Scheduler FSM: IDLE / SERVE.
  - IDLE: all queues empty. Moves to SERVE on the first edge where any queue is non-empty and load_slot holds.
  - SERVE selection rule, when load_slot && enable:
    - If queue[cur_q] is non-empty and credit>0: pop cur_q, credit-1.
    - Otherwise: search cur_q+1, cur_q+2, ... (mod NUM_QUEUES) for the first non-empty queue q. Pop q, set cur_q=q, credit=eff_weight(q)-1.
    - eff_weight = weight, or 1 when the weight is 0.
  - Returns to IDLE when nothing is selectable.
- Latency: push to an empty manager at edge t gives out_valid=1 after edge t+1.
- Throughput: 1 word/cycle with out_ready held high.
- enable=0: no pushes, no pops. The output register still completes a pending handshake (drains once), then out_valid clears.
- Weights are sampled only at the credit reload.

Optional Feature:
TM_STRICT_PRIO_EN
- Defined: queue 0 is strict-priority. At every selection, if queue 0 is non-empty it is popped, and cur_q/credit are left untouched. WRR covers queues 1..N-1 only.
- Undefined: queue 0 is an ordinary WRR participant.

Decomposition:
- Package tm_pkg: qidx_t, occupancy width constant OW, sched_state_e {IDLE, SERVE}.
- Sub-module tm_queue_fifo: one FIFO with push/pop, occupancy, full, empty; instantiated NUM_QUEUES times via generate.
- Scheduler and output stage stay in the top module.

Test Plan:
- WRR order: weights q0=1, q1=2, q2=1, q3=3; load 8 words into each queue; out_ready=1 -> out_queue sequence 0,1,1,2,3,3,3,0,1,1,...
- Tail drop: push 17 words into q2 with no pops -> occupancy[2]=16, queue_full[2]=1, drop_count=1; the 17th word never appears.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_queue stable; release -> words arrive in FIFO order with no loss or duplication.
- Zero weight: weight q1=0, q0 and q1 both loaded -> alternation 0,1,0,1.
- Reset mid-operation: with 10 words queued, rst_n=0 for 1 cycle -> all occupancy 0, out_valid 0, drop_count 0; new traffic then restarts from q0.
- TM_STRICT_PRIO_EN: q1/q2 backlogged; inject 1 word into q0 -> it is output at the next selection, and WRR resumes at the interrupted queue with its remaining credit.
